// File: rtl/framebuffer_write_mux.sv
// framebuffer_write_mux
// Concentrates pixel writes from N_CH Avalon-MM write masters into the single
// frame-buffer write port. Each channel has a private FIFO; a round-robin
// arbiter pops one entry per cycle into a registered output stage.
//
// Ports:
//   sys_clk, sys_rst_n       clock, asynchronous active-low reset
//   ch_avn_write[N_CH]       per-channel write strobe
//   ch_avn_address/writedata/byteenable   channel i packed at [i*W +: W]
//   ch_avn_waitrequest[N_CH] high while the channel FIFO is full
//   fb_avn_write/address/writedata/byteenable   registered frame-buffer write
//   fb_avn_waitrequest       frame-buffer backpressure
//   fb_grant_id              channel that sourced the current fb write
//   idle                     all FIFOs empty and no fb write pending
module framebuffer_write_mux #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned AVN_AW     = 19,
  parameter int unsigned AVN_DW     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned GW        = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned BW        = AVN_DW / 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [N_CH-1:0]        ch_avn_write,
  input  logic [N_CH*AVN_AW-1:0] ch_avn_address,
  input  logic [N_CH*AVN_DW-1:0] ch_avn_writedata,
  input  logic [N_CH*BW-1:0]     ch_avn_byteenable,
  output logic [N_CH-1:0]        ch_avn_waitrequest,
  output logic                   fb_avn_write,
  output logic [AVN_AW-1:0]      fb_avn_address,
  output logic [AVN_DW-1:0]      fb_avn_writedata,
  output logic [BW-1:0]          fb_avn_byteenable,
  input  logic                   fb_avn_waitrequest,
  output logic [GW-1:0]          fb_grant_id,
  output logic                   idle
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [AVN_AW-1:0] addr;
    logic [AVN_DW-1:0] data;
    logic [BW-1:0]     be;
  } ent_t;

  logic [N_CH-1:0] w_nempty;
  logic [N_CH-1:0] w_pop;
  ent_t            w_head [N_CH];

  logic            w_free;
  logic            w_found;
  logic [GW-1:0]   w_sel;
  logic [GW-1:0]   w_cand;

  logic            r_fb_write;
  ent_t            r_out;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_last;

  // Per-channel FIFOs
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    ent_t          r_mem [FIFO_DEPTH];
    logic          w_full;
    logic          w_push;
    ent_t          w_in;

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_push  = ch_avn_write[i] & ~w_full;
    assign w_in    = '{addr: ch_avn_address[i*AVN_AW +: AVN_AW],
                       data: ch_avn_writedata[i*AVN_DW +: AVN_DW],
                       be:   ch_avn_byteenable[i*BW +: BW]};
    assign w_nempty[i]           = (r_count != '0);
    assign w_head[i]             = r_mem[r_rp];
    assign ch_avn_waitrequest[i] = w_full;
    assign w_pop[i]              = w_free & w_found & (w_sel == GW'(i));

    // Pointers and occupancy; a full FIFO stays blocked even if popped this cycle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_count <= '0;
        r_wp    <= '0;
        r_rp    <= '0;
      end else begin
        if (w_push)   r_wp <= r_wp + PW'(1);
        if (w_pop[i]) r_rp <= r_rp + PW'(1);
        case ({w_push, w_pop[i]})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    // Storage array, no reset needed: validity is tracked by r_count
    always_ff @(posedge sys_clk) begin
      if (w_push) r_mem[r_wp] <= w_in;
    end
  end

  assign w_free = ~r_fb_write | ~fb_avn_waitrequest;

  // Round-robin scan starting one past the last granted channel
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      w_cand = GW'((32'(r_last) + k) % N_CH);
      if (!w_found && w_nempty[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  // Output register: loads only when the previous write has been taken
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_fb_write <= 1'b0;
      r_out      <= '0;
      r_grant    <= '0;
      r_last     <= GW'(N_CH - 1);
    end else if (w_free) begin
      if (w_found) begin
        r_fb_write <= 1'b1;
        r_out      <= w_head[w_sel];
        r_grant    <= w_sel;
        r_last     <= w_sel;
      end else begin
        r_fb_write <= 1'b0;
      end
    end
  end

  assign fb_avn_write      = r_fb_write;
  assign fb_avn_address    = r_out.addr;
  assign fb_avn_writedata  = r_out.data;
  assign fb_avn_byteenable = r_out.be;
  assign fb_grant_id       = r_grant;
  assign idle              = ~r_fb_write & ~(|w_nempty);

endmodule

// File: tb/tb_framebuffer_write_mux.sv
// Directed self-checking bench for framebuffer_write_mux (N_CH=4 defaults).
module tb_framebuffer_write_mux;

  localparam int unsigned N_CH = 4;
  localparam int unsigned AW   = 19;
  localparam int unsigned DW   = 16;
  localparam int unsigned BW   = DW / 8;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n;
  logic [N_CH-1:0]      ch_avn_write;
  logic [N_CH*AW-1:0]   ch_avn_address;
  logic [N_CH*DW-1:0]   ch_avn_writedata;
  logic [N_CH*BW-1:0]   ch_avn_byteenable;
  logic [N_CH-1:0]      ch_avn_waitrequest;
  logic                 fb_avn_write;
  logic [AW-1:0]        fb_avn_address;
  logic [DW-1:0]        fb_avn_writedata;
  logic [BW-1:0]        fb_avn_byteenable;
  logic                 fb_avn_waitrequest;
  logic [1:0]           fb_grant_id;
  logic                 idle;

  int n_cmp = 0;
  int n_err = 0;

  framebuffer_write_mux dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .ch_avn_write       (ch_avn_write),
    .ch_avn_address     (ch_avn_address),
    .ch_avn_writedata   (ch_avn_writedata),
    .ch_avn_byteenable  (ch_avn_byteenable),
    .ch_avn_waitrequest (ch_avn_waitrequest),
    .fb_avn_write       (fb_avn_write),
    .fb_avn_address     (fb_avn_address),
    .fb_avn_writedata   (fb_avn_writedata),
    .fb_avn_byteenable  (fb_avn_byteenable),
    .fb_avn_waitrequest (fb_avn_waitrequest),
    .fb_grant_id        (fb_grant_id),
    .idle               (idle)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
    ch_avn_write[ch]               = wr;
    ch_avn_address[ch*AW +: AW]    = a;
    ch_avn_writedata[ch*DW +: DW]  = d;
    ch_avn_byteenable[ch*BW +: BW] = be;
  endtask

  task automatic clr_all();
    ch_avn_write      = '0;
    ch_avn_address    = '0;
    ch_avn_writedata  = '0;
    ch_avn_byteenable = '0;
  endtask

  task automatic chk_fb(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be, input logic [1:0] g);
    chk({tag, "_wr"},   64'(fb_avn_write), 64'd1);
    chk({tag, "_addr"}, 64'(fb_avn_address), 64'(a));
    chk({tag, "_data"}, 64'(fb_avn_writedata), 64'(d));
    chk({tag, "_be"},   64'(fb_avn_byteenable), 64'(be));
    chk({tag, "_gid"},  64'(fb_grant_id), 64'(g));
  endtask

  initial begin : stim
    logic [1:0] exp_g;
    int         n_acc;

    // Reset state
    sys_rst_n = 1'b0;
    fb_avn_waitrequest = 1'b0;
    clr_all();
    tick();
    tick();
    chk("rst_fb_write", 64'(fb_avn_write), 64'd0);
    chk("rst_idle",     64'(idle), 64'd1);
    chk("rst_waitreq",  64'(ch_avn_waitrequest), 64'd0);
    chk("rst_addr",     64'(fb_avn_address), 64'd0);
    chk("rst_gid",      64'(fb_grant_id), 64'd0);
    sys_rst_n = 1'b1;
    tick();

    // Single write on ch0: one cycle latency, no bypass
    set_ch(0, 1'b1, 19'h00010, 16'hABCD, 2'b11);
    tick();
    clr_all();
    chk("single_nobypass", 64'(fb_avn_write), 64'd0);
    chk("single_busy",     64'(idle), 64'd0);
    tick();
    chk_fb("single", 19'h00010, 16'hABCD, 2'b11, 2'd0);
    tick();
    chk("single_done", 64'(fb_avn_write), 64'd0);
    chk("single_idle", 64'(idle), 64'd1);

    // Reset so channel 0 wins first again
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();

    // Simultaneous writes on all four channels
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 19'(32'h100 + i), 16'(32'h1000 + i), 2'b11);
    tick();
    clr_all();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_fb("simul", 19'(32'h100 + i), 16'(32'h1000 + i), 2'b11, 2'(i));
    end
    tick();
    chk("simul_done", 64'(fb_avn_write), 64'd0);
    chk("simul_idle", 64'(idle), 64'd1);

    // Backpressure: ch1 writes every cycle while the frame buffer stalls
    fb_avn_waitrequest = 1'b1;
    for (int k = 0; k < 12; k++) begin
      set_ch(1, 1'b1, 19'(32'h200 + k), 16'(32'h2000 + k), 2'b11);
      tick();
      chk("bp_waitreq", 64'(ch_avn_waitrequest[1]), 64'((k >= 4) ? 1 : 0));
      if (k >= 1) chk_fb("bp_hold", 19'h200, 16'h2000, 2'b11, 2'd1);
    end
    clr_all();
    fb_avn_waitrequest = 1'b0;
    chk_fb("bp_rel0", 19'h200, 16'h2000, 2'b11, 2'd1);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk_fb("bp_drain", 19'(32'h200 + k), 16'(32'h2000 + k), 2'b11, 2'd1);
      chk("bp_unblock", 64'(ch_avn_waitrequest[1]), 64'd0);
    end
    tick();
    chk("bp_done", 64'(fb_avn_write), 64'd0);
    chk("bp_idle", 64'(idle), 64'd1);

    // Fairness: ch0 and ch2 saturate, fb backpressure toggles; last grant was 1
    exp_g = 2'd2;
    n_acc = 0;
    set_ch(0, 1'b1, 19'h300, 16'h0A00, 2'b11);
    set_ch(2, 1'b1, 19'h302, 16'h0A02, 2'b11);
    for (int c = 0; c < 16; c++) begin
      fb_avn_waitrequest = c[0];
      #1;
      if (fb_avn_write && !fb_avn_waitrequest) begin
        chk("fair_grant", 64'(fb_grant_id), 64'(exp_g));
        exp_g = (exp_g == 2'd2) ? 2'd0 : 2'd2;
        n_acc++;
      end
      tick();
    end
    chk("fair_count", 64'(n_acc), 64'd7);
    clr_all();
    fb_avn_waitrequest = 1'b0;
    for (int c = 0; c < 40 && !idle; c++) tick();
    chk("fair_drain_idle", 64'(idle), 64'd1);

    // Ordering and byte enables on ch3
    set_ch(3, 1'b1, 19'd5, 16'h3005, 2'b01);
    tick();
    set_ch(3, 1'b1, 19'd6, 16'h3006, 2'b10);
    tick();
    chk_fb("ord0", 19'd5, 16'h3005, 2'b01, 2'd3);
    set_ch(3, 1'b1, 19'd7, 16'h3007, 2'b11);
    tick();
    clr_all();
    chk_fb("ord1", 19'd6, 16'h3006, 2'b10, 2'd3);
    tick();
    chk_fb("ord2", 19'd7, 16'h3007, 2'b11, 2'd3);
    tick();
    chk("ord_done", 64'(fb_avn_write), 64'd0);
    chk("ord_idle", 64'(idle), 64'd1);

    // Reset mid-burst
    fb_avn_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 1'b1, 19'(32'h400 + k), 16'(32'h4000 + k), 2'b11);
      set_ch(1, 1'b1, 19'(32'h410 + k), 16'(32'h4100 + k), 2'b11);
      tick();
    end
    clr_all();
    chk("mid_fb_write", 64'(fb_avn_write), 64'd1);
    chk("mid_busy",     64'(idle), 64'd0);
    sys_rst_n = 1'b0;
    #1;
    chk("arst_fb_write", 64'(fb_avn_write), 64'd0);
    chk("arst_idle",     64'(idle), 64'd1);
    chk("arst_addr",     64'(fb_avn_address), 64'd0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    fb_avn_waitrequest = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("post_rst_nostale", 64'(fb_avn_write), 64'd0);
      chk("post_rst_idle",    64'(idle), 64'd1);
    end
    set_ch(2, 1'b1, 19'h00022, 16'h5555, 2'b10);
    tick();
    clr_all();
    chk("post_rst_latency", 64'(fb_avn_write), 64'd0);
    tick();
    chk_fb("post_rst_ch2", 19'h00022, 16'h5555, 2'b10, 2'd2);
    tick();
    chk("post_rst_done", 64'(fb_avn_write), 64'd0);
    chk("post_rst_final_idle", 64'(idle), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time guard
  initial begin : guard
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/framebuffer_write_mux.md
# framebuffer_write_mux

Multi-channel write concentrator for the SRAM frame buffer. Accepts pixel writes from up to N_CH independent Avalon-MM write masters (one per parallel fractal compute core), buffers each channel in a private FIFO, and drains them round-robin into the single frame-buffer write port of the SRAM VGA controller. Several compute cores can then share one frame buffer without external glue.

## Interface
- N_CH, 4, number of write channels (1..16)
- AVN_AW, 19, Avalon address width
- AVN_DW, 16, Avalon data width (multiple of 8)
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, ≥2)
- GW, $clog2(N_CH) (1 when N_CH=1), grant id width (localparam)

- sys_clk  in  1  sole clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- ch_avn_write  in  N_CH  per-channel write request
- ch_avn_address  in  N_CH*AVN_AW  channel i at bits [i*AVN_AW +: AVN_AW]
- ch_avn_writedata  in  N_CH*AVN_DW  packed likewise
- ch_avn_byteenable  in  N_CH*AVN_DW/8  packed likewise
- ch_avn_waitrequest  out  N_CH  high = channel FIFO full, write not accepted
- fb_avn_write  out  1  write to frame buffer
- fb_avn_address  out  AVN_AW  frame-buffer address
- fb_avn_writedata  out  AVN_DW  frame-buffer data
- fb_avn_byteenable  out  AVN_DW/8  frame-buffer byte enables
- fb_avn_waitrequest  in  1  frame-buffer backpressure
- fb_grant_id  out  GW  channel that sourced the current fb write; valid when fb_avn_write=1
- idle  out  1  all FIFOs empty and fb_avn_write=0

## Operation
- Reset (async, sys_rst_n=0): all FIFOs empty, fb_avn_write=0, fb address/data/byteenable/grant_id=0, last-grant pointer=N_CH-1 (channel 0 wins first), ch_avn_waitrequest=0, idle=1. Reset mid-burst discards all buffered and in-flight writes; fb_avn_write drops immediately.
- Channel push: entry {address, writedata, byteenable} written when ch_avn_write[i]=1 and ch_avn_waitrequest[i]=0. ch_avn_waitrequest[i] = (count_i == FIFO_DEPTH), decoded from registered count; a pop in the same cycle does not unblock a full FIFO.
- Push and pop on the same non-full FIFO in one cycle: count unchanged, both take effect.
- Output register "free" when fb_avn_write=0, or fb_avn_write=1 and fb_avn_waitrequest=0.
- When free: scan channels starting at last_grant+1 mod N_CH, pick first non-empty FIFO, pop its head into output register, set fb_avn_write=1, fb_grant_id=i, last_grant=i. No non-empty FIFO: fb_avn_write=0 next cycle, other outputs hold, last_grant unchanged.
- When not free: all fb_* outputs and fb_grant_id held stable; no pop.
- Ordering: per-channel FIFO order preserved; across channels strict round-robin among non-empty channels.
- FIFO pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
- No read path; read requests are outside this block.

## Timing
- Latency: write accepted at edge E0 into an empty FIFO with output free -> fb_avn_write=1 with that entry after E1 (one cycle; no bypass).
- Throughput: one fb write per cycle while fb_avn_waitrequest=0 and any FIFO non-empty.
- Per channel: one push per cycle max; capacity FIFO_DEPTH entries plus one in the output register.
- idle is registered-state decode: 1 cycle after the last fb write is accepted, with all FIFOs empty.

## Test plan
- Single write: ch0 addr 0x00010, data 0xABCD, be 2'b11 at E0 -> after E1 fb_avn_write=1 with those values, fb_grant_id=0; accepted next edge; idle=1 one cycle later.
- Simultaneous: all 4 channels write once at E0 (ch i data 0x1000+i), fb_waitrequest=0 -> fb writes data 0x1000,0x1001,0x1002,0x1003 on four consecutive cycles, grant ids 0..3.
- Backpressure: fb_avn_waitrequest=1 for 12 cycles, ch1 writes every cycle -> 5 writes accepted, ch_avn_waitrequest[1]=1 from 6th; fb outputs stable throughout; after release, 5 writes emerge in order, one per cycle.
- Fairness: ch0 and ch2 write continuously, fb_waitrequest toggles 0/1 -> grant sequence alternates 0,2,0,2; ch1/ch3 never granted.
- Ordering/byteenable: ch3 writes be 2'b01, 2'b10, 2'b11 to addr 5,6,7 -> fb emits same triples in same order.
- Reset mid-burst: FIFOs half full, fb_avn_write=1, sys_rst_n low for 2 cycles -> fb_avn_write=0 asynchronously, idle=1, no stale entry appears after release; next write on ch2 is granted first-come.
